// File: rtl/xnor3_share_arbiter.sv
`default_nettype none
// ============================================================================
// xnor3_share_arbiter: round-robin sharing of one 3-input XNOR unit
// Revision: 1.0
// ============================================================================
module xnor3_share_arbiter #(
  parameter int NREQ        = 4,
  parameter int EVAL_CYCLES = 2,
  parameter int IDW         = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] a_in,
  input  logic [NREQ-1:0] b_in,
  input  logic [NREQ-1:0] c_in,
  output logic [NREQ-1:0] gnt,
  output logic            busy,
  output logic            f_valid,
  output logic            f_out,
  output logic [IDW-1:0]  f_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [IDW-1:0] PTR_RST  = IDW'(NREQ - 1);
  localparam logic [3:0]     CNT_LAST = 4'(EVAL_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  f_id_q, f_id_d;
  logic            a_l_q, a_l_d;
  logic            b_l_q, b_l_d;
  logic            c_l_q, c_l_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            f_valid_q, f_valid_d;
  logic            f_out_q, f_out_d;

  logic            found_hi, found_lo, win_found;
  logic [IDW-1:0]  idx_hi, idx_lo, win_idx;

  // Round-robin: lowest requester above ptr first, otherwise lowest at or below ptr.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (IDW'(i) > ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = IDW'(i);
      end
      if (req[i] && (IDW'(i) <= ptr_q)) begin
        found_lo = 1'b1;
        idx_lo   = IDW'(i);
      end
    end
    win_found = found_hi | found_lo;
    win_idx   = found_hi ? idx_hi : idx_lo;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    f_id_d    = f_id_q;
    a_l_d     = a_l_q;
    b_l_d     = b_l_q;
    c_l_d     = c_l_q;
    gnt_d     = '0;
    f_valid_d = 1'b0;
    f_out_d   = f_out_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
          a_l_d   = a_in[win_idx];
          b_l_d   = b_in[win_idx];
          c_l_d   = c_in[win_idx];
          f_id_d  = win_idx;
          cnt_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          f_out_d   = ~(a_l_q ^ b_l_q ^ c_l_q);
          f_valid_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        ptr_d   = f_id_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= PTR_RST;
      f_id_q    <= '0;
      a_l_q     <= 1'b0;
      b_l_q     <= 1'b0;
      c_l_q     <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      f_valid_q <= 1'b0;
      f_out_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      f_id_q    <= f_id_d;
      a_l_q     <= a_l_d;
      b_l_q     <= b_l_d;
      c_l_q     <= c_l_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      f_valid_q <= f_valid_d;
      f_out_q   <= f_out_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign f_valid = f_valid_q;
  assign f_out   = f_out_q;
  assign f_id    = f_id_q;

endmodule
`default_nettype wire

// File: tb/tb_xnor3_share_arbiter.sv
`default_nettype none
// ============================================================================
// tb_xnor3_share_arbiter: directed vectors for the shared XNOR arbiter
// Revision: 1.0
// ============================================================================
module tb_xnor3_share_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req, a_in, b_in, c_in;
  logic [3:0] gnt;
  logic       busy, f_valid, f_out;
  logic [1:0] f_id;

  logic [3:0] req1, a1, b1, c1;
  logic [3:0] gnt1;
  logic       busy1, f_valid1, f_out1;
  logic [1:0] f_id1;

  int n_cmp;
  int n_bad;

  xnor3_share_arbiter #(.NREQ(4), .EVAL_CYCLES(2), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .gnt(gnt), .busy(busy), .f_valid(f_valid), .f_out(f_out), .f_id(f_id)
  );

  xnor3_share_arbiter #(.NREQ(4), .EVAL_CYCLES(1), .IDW(2)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .a_in(a1), .b_in(b1), .c_in(c1),
    .gnt(gnt1), .busy(busy1), .f_valid(f_valid1), .f_out(f_out1), .f_id(f_id1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] id;
  } rr_vec_t;

  typedef struct {
    logic a;
    logic b;
    logic c;
    logic f;
  } sweep_vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the EVAL_CYCLES=2 instance, ending in the following IDLE cycle.
  task automatic txn(input string tag, input logic [3:0] r, input logic [3:0] a,
                     input logic [3:0] b, input logic [3:0] c, input logic [3:0] eg,
                     input logic ef, input logic [1:0] eid);
    req = r; a_in = a; b_in = b; c_in = c;
    step();
    chk({tag, ".gnt"}, 8'(gnt), 8'(eg));
    chk({tag, ".busy"}, 8'(busy), 8'd1);
    step();
    chk({tag, ".gnt_off"}, 8'(gnt), 8'd0);
    chk({tag, ".early_valid"}, 8'(f_valid), 8'd0);
    step();
    chk({tag, ".f_valid"}, 8'(f_valid), 8'd1);
    chk({tag, ".f_out"}, 8'(f_out), 8'(ef));
    chk({tag, ".f_id"}, 8'(f_id), 8'(eid));
    step();
    chk({tag, ".valid_off"}, 8'(f_valid), 8'd0);
    chk({tag, ".idle"}, 8'(busy), 8'd0);
  endtask

  rr_vec_t    rr_tab[5];
  sweep_vec_t sw_tab[8];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rr_tab[0] = '{4'b0001, 2'd0};
    rr_tab[1] = '{4'b0010, 2'd1};
    rr_tab[2] = '{4'b0100, 2'd2};
    rr_tab[3] = '{4'b1000, 2'd3};
    rr_tab[4] = '{4'b0001, 2'd0};
    sw_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
    sw_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    sw_tab[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    sw_tab[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    sw_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    sw_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
    sw_tab[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    sw_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    req = '0; a_in = '0; b_in = '0; c_in = '0;
    req1 = '0; a1 = '0; b1 = '0; c1 = '0;
    step();
    step();
    chk("rst.gnt", 8'(gnt), 8'd0);
    chk("rst.busy", 8'(busy), 8'd0);
    chk("rst.f_valid", 8'(f_valid), 8'd0);
    chk("rst.f_out", 8'(f_out), 8'd0);
    chk("rst.f_id", 8'(f_id), 8'd0);
    rst = 1'b0;
    step();
    chk("idle.no_req_gnt", 8'(gnt), 8'd0);

    // Single requester, all operands one: XNOR of three ones is 0
    txn("t1", 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);

    // Full round robin from reset pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++)
      txn($sformatf("t2[%0d]", i), 4'b1111, 4'b0000, 4'b0000, 4'b0000,
          rr_tab[i].gnt, 1'b1, rr_tab[i].id);

    // Sparse requests after requester 0 was served
    txn("t3a", 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 1'b0, 2'd2);
    txn("t3b", 4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0001, 1'b0, 2'd0);

    // Operands and req change after capture must not matter
    req = 4'b1000; a_in = 4'b1000; b_in = 4'b1000; c_in = 4'b0000;
    step();
    chk("t4.gnt", 8'(gnt), 8'b1000);
    req = 4'b0000; a_in = 4'b0000; b_in = 4'b0000; c_in = 4'b1000;
    step();
    step();
    chk("t4.f_valid", 8'(f_valid), 8'd1);
    chk("t4.f_out", 8'(f_out), 8'd1);
    chk("t4.f_id", 8'(f_id), 8'd3);
    step();

    // Move pointer to 1, then abort a grant to 0 with reset
    txn("t5pre", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1);
    req = 4'b0001;
    step();
    chk("t5.gnt", 8'(gnt), 8'b0001);
    rst = 1'b1;
    req = 4'b0000;
    step();
    rst = 1'b0;
    chk("t5.busy", 8'(busy), 8'd0);
    chk("t5.gnt_clr", 8'(gnt), 8'd0);
    chk("t5.f_valid", 8'(f_valid), 8'd0);
    chk("t5.f_id", 8'(f_id), 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t5.no_strobe[%0d]", i), 8'(f_valid), 8'd0);
    end
    // Pointer back at 3: requester 1 beats requester 2
    txn("t5post", 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1, 2'd1);

    // Truth-table sweep on requester 2 of the single-cycle instance
    req = '0;
    for (int i = 0; i < 8; i++) begin
      req1 = 4'b0100;
      a1 = {1'b0, sw_tab[i].a, 2'b00};
      b1 = {1'b0, sw_tab[i].b, 2'b00};
      c1 = {1'b0, sw_tab[i].c, 2'b00};
      step();
      chk($sformatf("t6[%0d].gnt", i), 8'(gnt1), 8'b0100);
      chk($sformatf("t6[%0d].early", i), 8'(f_valid1), 8'd0);
      step();
      chk($sformatf("t6[%0d].f_valid", i), 8'(f_valid1), 8'd1);
      chk($sformatf("t6[%0d].f_out", i), 8'(f_out1), 8'(sw_tab[i].f));
      chk($sformatf("t6[%0d].f_id", i), 8'(f_id1), 8'd2);
      step();
      chk($sformatf("t6[%0d].valid_off", i), 8'(f_valid1), 8'd0);
    end
    req1 = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
